// File: rtl/reg_alu_sequencer.sv
// reg_alu_sequencer
//
// Instruction sequencer that sits in front of a register file and an ALU.
// It accepts one encoded instruction at a time over a valid/ready handshake.
// Each instruction then runs through a fixed four-state sequence:
//   IDLE  -> accept the instruction and present its read addresses
//   READ  -> capture both operands into the ALU instruction word
//   EXEC  -> register the write-back value (ALU result, or the immediate for LOADI)
//   WRITE -> write_en is high, and the register file commits at the closing edge
// Every output comes straight from a flop.
//
// Ports
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready   instruction handshake; in_ready is high only in IDLE
//   in_instr              [11:9] op, [8:6] rd, [5:3] rs1, [2:0] rs2
//   in_imm                immediate; it is written only when op = 000 (LOADI)
//   read_addr1/2          register-file read addresses (rs1, rs2)
//   read_out1/2           register-file read data (combinational read)
//   alu_ins               {op, operand1, operand2} driven to the ALU
//   alu_out               ALU result (combinational)
//   write_addr, data_in   register-file write address and data
//   write_en              register-file write strobe, one cycle per instruction
//   done                  one-cycle pulse in the first IDLE cycle after a write
//   retired               count of retired instructions; it wraps
module reg_alu_sequencer #(
  parameter int DW    = 12,
  parameter int AW    = 3,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [11:0]         in_instr,
  input  logic [DW-1:0]       in_imm,
  output logic [AW-1:0]       read_addr1,
  output logic [AW-1:0]       read_addr2,
  input  logic [DW-1:0]       read_out1,
  input  logic [DW-1:0]       read_out2,
  output logic [3+2*DW-1:0]   alu_ins,
  input  logic [DW-1:0]       alu_out,
  output logic [AW-1:0]       write_addr,
  output logic [DW-1:0]       data_in,
  output logic                write_en,
  output logic                done,
  output logic [CNT_W-1:0]    retired
);

  localparam logic [2:0] OP_LOADI = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t        state;
  logic [2:0]    op;
  logic [DW-1:0] imm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Any in-flight instruction is dropped. write_en is cleared, so no write occurs.
      state      <= IDLE;
      in_ready   <= 1'b1;
      read_addr1 <= '0;
      read_addr2 <= '0;
      write_addr <= '0;
      data_in    <= '0;
      alu_ins    <= '0;
      write_en   <= 1'b0;
      done       <= 1'b0;
      retired    <= '0;
      op         <= '0;
      imm        <= '0;
    end else begin
      case (state)
        // Accept: latch the instruction and present the addresses for the next cycle.
        IDLE: begin
          done <= 1'b0;
          if (in_valid) begin
            op         <= in_instr[11:9];
            write_addr <= in_instr[8:6];
            read_addr1 <= in_instr[5:3];
            read_addr2 <= in_instr[2:0];
            imm        <= in_imm;
            in_ready   <= 1'b0;
            state      <= READ;
          end
        end
        // Operand capture: the register file reads the old contents here, so
        // rd may alias rs1/rs2 without any forwarding.
        READ: begin
          alu_ins <= {op, read_out1, read_out2};
          state   <= EXEC;
        end
        // Execute: alu_ins stays stable, so alu_out is settled and can be registered.
        EXEC: begin
          data_in  <= (op == OP_LOADI) ? imm : alu_out;
          write_en <= 1'b1;
          state    <= WRITE;
        end
        // Write-back: the register file commits at this closing edge.
        WRITE: begin
          write_en <= 1'b0;
          done     <= 1'b1;
          retired  <= retired + 1'b1;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// Directed bench for reg_alu_sequencer. The bench supplies an 8-entry register
// file that resets to zero, with combinational reads and writes on the rising
// edge when write_en is high. It also supplies a small stub ALU. Expected values
// below are hand-computed from that stub:
//   op 001 add, op 010 sub, op 101 add, everything else passes operand 1.
module tb_reg_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_instr;
  logic [11:0] in_imm;
  logic [2:0]  read_addr1, read_addr2;
  logic [11:0] read_out1, read_out2;
  logic [26:0] alu_ins;
  logic [11:0] alu_out;
  logic [2:0]  write_addr;
  logic [11:0] data_in;
  logic        write_en;
  logic        done;
  logic [7:0]  retired;

  int n_chk  = 0;
  int n_fail = 0;

  logic [11:0] regs [8];
  int write_count = 0;
  int we_double   = 0;
  int cyc         = 0;
  logic prev_we   = 1'b0;

  always #5 clk = ~clk;

  reg_alu_sequencer #(.DW(12), .AW(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_imm(in_imm),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_out1(read_out1), .read_out2(read_out2),
    .alu_ins(alu_ins), .alu_out(alu_out),
    .write_addr(write_addr), .data_in(data_in), .write_en(write_en),
    .done(done), .retired(retired)
  );

  function automatic logic [11:0] alu_stub(input logic [2:0] op, input logic [11:0] a, input logic [11:0] b);
    case (op)
      3'b001:  return a + b;
      3'b010:  return a - b;
      3'b101:  return a + b;
      default: return a;
    endcase
  endfunction

  assign read_out1 = regs[read_addr1];
  assign read_out2 = regs[read_addr2];
  assign alu_out   = alu_stub(alu_ins[26:24], alu_ins[23:12], alu_ins[11:0]);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (write_en) begin
      regs[write_addr] <= data_in;
    end
  end

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    prev_we <= write_en;
    if (write_en) write_count <= write_count + 1;
    if (write_en && prev_we) we_double <= we_double + 1;
  end

  // Presents one instruction and holds it until it is accepted.
  // Returns #1 after the accept edge with in_valid dropped.
  task automatic accept(input logic [11:0] instr, input logic [11:0] imm, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_instr = instr; in_imm = imm;
    for (int c = 0; c < 12; c++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Waits, sampling on falling edges, until done is seen or the budget runs out.
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bit ok;
    int wc;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_imm = '0;
    repeat (2) @(negedge clk);
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    n_chk++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL rst_write_en: got %b expected 0", write_en); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
    n_chk++; if (retired !== 8'd0) begin n_fail++; $display("FAIL rst_retired: got %0d expected 0", retired); end
    n_chk++; if ({read_addr1, read_addr2, write_addr, data_in, alu_ins} !== '0) begin n_fail++; $display("FAIL rst_data_regs: got nonzero expected 0"); end
    rst_n = 1'b1;
    // Start op 001 rd3 rs1=1 rs2=2, then reset it during EXEC.
    accept(12'o1312, 12'h0, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rst_accept: got timeout expected accept"); end
    @(negedge clk);  // READ
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL read_in_ready: got %b expected 0", in_ready); end
    @(negedge clk);  // EXEC
    n_chk++; if (alu_ins !== 27'h1000000) begin n_fail++; $display("FAIL exec_alu_ins_pre_rst: got %h expected 1000000", alu_ins); end
    wc = write_count;
    rst_n = 1'b0;
    #1;
    n_chk++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL midrst_write_en: got %b expected 0", write_en); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    n_chk++; if (retired !== 8'd0) begin n_fail++; $display("FAIL midrst_retired: got %0d expected 0", retired); end
    n_chk++; if (alu_ins !== 27'h0) begin n_fail++; $display("FAIL midrst_alu_ins: got %h expected 0", alu_ins); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_chk++; if (write_count !== wc) begin n_fail++; $display("FAIL midrst_no_write: got %0d writes expected %0d", write_count, wc); end
    n_chk++; if (done !== 1'b0 || retired !== 8'd0) begin n_fail++; $display("FAIL midrst_no_retire: got done=%b retired=%0d expected 0/0", done, retired); end
  endtask

  task automatic test_loadi();
    bit ok;
    accept(12'o0000, 12'hF7C, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL loadi0_accept: got timeout expected accept"); end
    repeat (3) @(negedge clk);  // READ, EXEC, WRITE
    n_chk++; if (write_en !== 1'b1 || write_addr !== 3'd0 || data_in !== 12'hF7C) begin n_fail++; $display("FAIL loadi0_write: got we=%b addr=%0d data=%h expected 1/0/f7c", write_en, write_addr, data_in); end
    @(negedge clk);  // IDLE
    n_chk++; if (done !== 1'b1 || write_en !== 1'b0 || retired !== 8'd1) begin n_fail++; $display("FAIL loadi0_retire: got done=%b we=%b retired=%0d expected 1/0/1", done, write_en, retired); end
    accept(12'o0100, 12'h002, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL loadi1_accept: got timeout expected accept"); end
    repeat (3) @(negedge clk);
    n_chk++; if (write_en !== 1'b1 || write_addr !== 3'd1 || data_in !== 12'h002) begin n_fail++; $display("FAIL loadi1_write: got we=%b addr=%0d data=%h expected 1/1/002", write_en, write_addr, data_in); end
    @(negedge clk);
    n_chk++; if (retired !== 8'd2) begin n_fail++; $display("FAIL loadi_retired: got %0d expected 2", retired); end
    n_chk++; if (regs[0] !== 12'hF7C || regs[1] !== 12'h002) begin n_fail++; $display("FAIL loadi_regs: got r0=%h r1=%h expected f7c/002", regs[0], regs[1]); end
  endtask

  task automatic test_alu_op();
    bit ok;
    accept(12'o1201, 12'h0, ok);  // op001 rd2 rs1=0 rs2=1
    n_chk++; if (!ok) begin n_fail++; $display("FAIL alu_accept: got timeout expected accept"); end
    @(negedge clk);  // READ
    n_chk++; if (read_addr1 !== 3'd0 || read_addr2 !== 3'd1) begin n_fail++; $display("FAIL alu_read_addr: got %0d/%0d expected 0/1", read_addr1, read_addr2); end
    @(negedge clk);  // EXEC
    n_chk++; if (alu_ins !== 27'h1F7C002) begin n_fail++; $display("FAIL alu_ins: got %h expected 1f7c002", alu_ins); end
    @(negedge clk);  // WRITE
    n_chk++; if (write_en !== 1'b1 || write_addr !== 3'd2 || data_in !== 12'hF7E) begin n_fail++; $display("FAIL alu_write: got we=%b addr=%0d data=%h expected 1/2/f7e", write_en, write_addr, data_in); end
    @(negedge clk);  // IDLE
    n_chk++; if (done !== 1'b1 || retired !== 8'd3 || regs[2] !== 12'hF7E) begin n_fail++; $display("FAIL alu_retire: got done=%b retired=%0d r2=%h expected 1/3/f7e", done, retired, regs[2]); end
    @(negedge clk);
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL alu_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_same_reg();
    bit ok;
    accept(12'o0500, 12'h440, ok);
    wait_done(ok);
    n_chk++; if (!ok || regs[5] !== 12'h440) begin n_fail++; $display("FAIL same_preload: got r5=%h expected 440", regs[5]); end
    accept(12'o5555, 12'h0, ok);  // op101 rd=rs1=rs2=5
    n_chk++; if (!ok) begin n_fail++; $display("FAIL same_accept: got timeout expected accept"); end
    repeat (2) @(negedge clk);  // READ, EXEC
    n_chk++; if (alu_ins !== 27'h5440440) begin n_fail++; $display("FAIL same_alu_ins: got %h expected 5440440", alu_ins); end
    @(negedge clk);  // WRITE
    n_chk++; if (data_in !== 12'h880 || write_addr !== 3'd5) begin n_fail++; $display("FAIL same_write: got addr=%0d data=%h expected 5/880", write_addr, data_in); end
    @(negedge clk);
    n_chk++; if (regs[5] !== 12'h880 || retired !== 8'd5) begin n_fail++; $display("FAIL same_result: got r5=%h retired=%0d expected 880/5", regs[5], retired); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] prog [4];
    logic [11:0] imms [4];
    int acc_cyc [4];
    int wc0;
    bit ok;
    // r3=010; r4=r3+r1=012; r6=r4+r4=024; r7=r6-r1=022
    prog = '{12'o0300, 12'o1431, 12'o1644, 12'o2761};
    imms = '{12'h010, 12'h0, 12'h0, 12'h0};
    wc0 = write_count;
    @(negedge clk);
    in_valid = 1'b1; in_instr = prog[0]; in_imm = imms[0];
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      for (int c = 0; c < 12; c++) begin
        if (in_ready) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      acc_cyc[k] = cyc;
      @(posedge clk); #1;
      if (k < 3) begin in_instr = prog[k+1]; in_imm = imms[k+1]; end
      else in_valid = 1'b0;
      n_chk++; if (!ok) begin n_fail++; $display("FAIL b2b_accept%0d: got timeout expected accept", k); end
      if (k > 0) begin
        n_chk++; if (acc_cyc[k] - acc_cyc[k-1] != 4) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d cycles expected 4", k, acc_cyc[k] - acc_cyc[k-1]); end
      end
      @(negedge clk);
    end
    wait_done(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL b2b_done: got timeout expected done"); end
    n_chk++; if (write_count - wc0 != 4) begin n_fail++; $display("FAIL b2b_write_count: got %0d expected 4", write_count - wc0); end
    n_chk++; if (regs[3] !== 12'h010 || regs[4] !== 12'h012 || regs[6] !== 12'h024 || regs[7] !== 12'h022) begin n_fail++; $display("FAIL b2b_raw_chain: got r3=%h r4=%h r6=%h r7=%h expected 010/012/024/022", regs[3], regs[4], regs[6], regs[7]); end
    n_chk++; if (retired !== 8'd9) begin n_fail++; $display("FAIL b2b_retired: got %0d expected 9", retired); end
  endtask

  task automatic test_wrap();
    bit ok_a, ok_d;
    int timeouts = 0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 256; k++) begin
      accept(12'o0000, 12'(k), ok_a);
      wait_done(ok_d);
      if (!ok_a || !ok_d) timeouts++;
      if (k == 254) begin
        n_chk++; if (retired !== 8'hFF) begin n_fail++; $display("FAIL wrap_255: got %0d expected 255", retired); end
      end
    end
    n_chk++; if (timeouts != 0) begin n_fail++; $display("FAIL wrap_timeouts: got %0d expected 0", timeouts); end
    n_chk++; if (done !== 1'b1 || retired !== 8'd0) begin n_fail++; $display("FAIL wrap_zero: got done=%b retired=%0d expected 1/0", done, retired); end
    n_chk++; if (regs[0] !== 12'h0FF) begin n_fail++; $display("FAIL wrap_last_write: got %h expected 0ff", regs[0]); end
  endtask

  initial begin
    test_reset();
    test_loadi();
    test_alu_op();
    test_same_reg();
    test_back_to_back();
    test_wrap();
    n_chk++; if (we_double != 0) begin n_fail++; $display("FAIL write_en_single: got %0d double-cycle pulses expected 0", we_double); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
